sd_cmd_issue_ctrl: RTL

Command-issue controller that sits directly upstream of the SD command serial host, in the SD_CLK_IN domain. It accepts one command request from the register/DMA side, packs the 40-bit command word and the 16-bit setting word, and drives the host's REQ/ACK handshake. It also consumes the host's status events and returns the response, completion and error flags to the register side. Optionally, it aborts a stalled command by pulsing GO_IDLE.

---
 rtl/sd_cmd_pkg.sv | 60 ++++++
 rtl/sd_cmd_timeout.sv | 32 +++
 rtl/sd_cmd_issue_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD command-issue controller and its
// timeout counter.
package sd_cmd_pkg;

  localparam int unsigned CMD_W   = 40;
  localparam int unsigned SET_W   = 16;
  localparam int unsigned TMO_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_SEND     = 3'd2,
    ST_RUN      = 3'd3,
    ST_FIN      = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam logic [1:0] RSP_NONE = 2'b00;
  localparam logic [1:0] RSP_48   = 2'b01;
  localparam logic [1:0] RSP_136  = 2'b10;

  localparam logic [6:0] RSP_LEN_48  = 7'd40;
  localparam logic [6:0] RSP_LEN_136 = 7'd127;

  // Host STATUS[3:0] phase codes
  localparam logic [3:0] PH_START    = 4'd1;
  localparam logic [3:0] PH_CMD      = 4'd2;
  localparam logic [3:0] PH_WAIT     = 4'd3;
  localparam logic [3:0] PH_NO_RSP   = 4'd4;
  localparam logic [3:0] PH_RSP      = 4'd5;
  localparam logic [3:0] PH_RSP_DONE = 4'd6;

  localparam int unsigned STAT_CRC_OK_BIT = 5;
  localparam int unsigned STAT_FINAL_BIT  = 6;

  typedef struct packed {
    logic [1:0]  pre;
    logic [5:0]  idx;
    logic [31:0] arg;
  } cmd_t;

  typedef struct packed {
    logic       rsvd;
    logic [1:0] word_sel;
    logic       blk_rd;
    logic       blk_wr;
    logic [2:0] norsp_dly;
    logic       crc_chk;
    logic [6:0] rsp_len;
  } setting_t;

  function automatic logic [6:0] rsp_len(input logic [1:0] rt);
    case (rt)
      RSP_48:  return RSP_LEN_48;
      RSP_136: return RSP_LEN_136;
      default: return 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/sd_cmd_timeout.sv
// Stall watchdog: counts enabled cycles and flags the cycle that completes
// TIMEOUT_CYC of them. Only built when SD_CMD_TIMEOUT_EN is defined.
`ifdef SD_CMD_TIMEOUT_EN
module sd_cmd_timeout
  import sd_cmd_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
  input  logic SD_CLK_IN,
  input  logic RST_IN,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_c_o
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + TMO_W'(1);
  end

  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_c_o = en_i && (cnt_q == (TIMEOUT_CYC - 16'd1));

endmodule
`endif

// File: rtl/sd_cmd_issue_ctrl.sv
// Issues one SD command to the serial host via REQ/ACK and returns response/
// error status. SD_CMD_TIMEOUT_EN adds a stall timeout that pulses GO_IDLE.
module sd_cmd_issue_ctrl
  import sd_cmd_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF,
  parameter logic [2:0]  NORSP_DLY   = 3'd7
) (
  input  logic              SD_CLK_IN,
  input  logic              RST_IN,
  input  logic              start_i,
  input  logic [5:0]        cmd_idx_i,
  input  logic [31:0]       arg_i,
  input  logic [1:0]        rsp_type_i,
  input  logic              crc_chk_i,
  input  logic              idx_chk_i,
  input  logic              blk_rd_i,
  input  logic              blk_wr_i,
  input  logic [1:0]        word_sel_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        err_o,
  output logic [CMD_W-1:0]  rsp_o,
  output logic [SET_W-1:0]  setting_o,
  output logic [CMD_W-1:0]  cmd_o,
  output logic              req_o,
  input  logic              host_ack_i,
  input  logic              ev_req_i,
  output logic              ev_ack_o,
  input  logic [7:0]        status_i,
  input  logic [CMD_W-1:0]  resp_i,
  output logic              go_idle_o
);

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  setting_t         set_q, set_d;
  logic [1:0]       rsp_type_q, rsp_type_d;
  logic             idx_chk_q, idx_chk_d;
  logic [2:0]       err_q, err_d;
  logic [CMD_W-1:0] rsp_q, rsp_d;
  logic             busy_q, done_q, req_q, ev_ack_q;
  logic [1:0]       rt_norm_c;
  logic             final_ev_c;
  logic             tmo_hit_c;
  logic             unused_c;

  assign rt_norm_c  = (rsp_type_i == 2'b11) ? RSP_NONE : rsp_type_i;
  assign final_ev_c = ev_req_i && status_i[STAT_FINAL_BIT];
  assign unused_c   = ^{status_i[7], status_i[4]};

`ifdef SD_CMD_TIMEOUT_EN
  logic tmo_c;
  logic go_idle_q;

  sd_cmd_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .SD_CLK_IN  (SD_CLK_IN),
    .RST_IN     (RST_IN),
    .en_i       ((state_q == ST_RUN) || (state_q == ST_FIN)),
    .clr_i      ((state_q == ST_SEND) && !host_ack_i),
    .expire_c_o (tmo_c)
  );

  // Normal FIN exit beats a coincident timeout
  assign tmo_hit_c = tmo_c && !((state_q == ST_FIN) && host_ack_i);

  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) go_idle_q <= 1'b0;
    else        go_idle_q <= tmo_hit_c;
  end
  assign go_idle_o = go_idle_q;
`else
  logic [15:0] unused_tmo_c;
  assign unused_tmo_c = TIMEOUT_CYC;
  assign tmo_hit_c    = 1'b0;
  assign go_idle_o    = 1'b0;
`endif

  // Next-state, latch and status-capture logic
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    set_d      = set_q;
    rsp_type_d = rsp_type_q;
    idx_chk_d  = idx_chk_q;
    err_d      = err_q;
    rsp_d      = rsp_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d         = ST_WAIT_RDY;
          err_d           = 3'b000;
          rsp_type_d      = rt_norm_c;
          idx_chk_d       = idx_chk_i;
          cmd_d.pre       = 2'b01;
          cmd_d.idx       = cmd_idx_i;
          cmd_d.arg       = arg_i;
          set_d.rsvd      = 1'b0;
          set_d.word_sel  = word_sel_i;
          set_d.blk_rd    = blk_rd_i;
          set_d.blk_wr    = blk_wr_i;
          set_d.norsp_dly = (rt_norm_c == RSP_NONE) ? NORSP_DLY : 3'd0;
          set_d.crc_chk   = crc_chk_i;
          set_d.rsp_len   = rsp_len(rt_norm_c);
        end
      end
      ST_WAIT_RDY: if (host_ack_i) state_d = ST_SEND;
      ST_SEND:     if (!host_ack_i) state_d = ST_RUN;
      ST_RUN: begin
        if (tmo_hit_c) begin
          state_d  = ST_DONE;
          err_d[2] = 1'b1;
        end else if (final_ev_c) begin
          state_d  = ST_FIN;
          if (status_i[3:0] == PH_RSP_DONE) rsp_d = resp_i;
          err_d[0] = set_q.crc_chk & ~status_i[STAT_CRC_OK_BIT];
          err_d[1] = idx_chk_q & (rsp_type_q == RSP_48) & (resp_i[37:32] != cmd_q.idx);
        end
      end
      ST_FIN: begin
        if (host_ack_i) begin
          state_d = ST_DONE;
        end else if (tmo_hit_c) begin
          state_d  = ST_DONE;
          err_d[2] = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they land with it
  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      set_q      <= '0;
      rsp_type_q <= RSP_NONE;
      idx_chk_q  <= 1'b0;
      err_q      <= 3'b000;
      rsp_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      ev_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      set_q      <= set_d;
      rsp_type_q <= rsp_type_d;
      idx_chk_q  <= idx_chk_d;
      err_q      <= err_d;
      rsp_q      <= rsp_d;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
      req_q      <= (state_d == ST_SEND);
      ev_ack_q   <= (state_d == ST_FIN);
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rsp_o     = rsp_q;
  assign cmd_o     = cmd_q;
  assign setting_o = set_q;
  assign req_o     = req_q;
  assign ev_ack_o  = ev_ack_q;

endmodule
